// File: rtl/pp_mem_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store) stages.
// Optional stall-cycle performance counters are built when ARB_PERF_CNT_EN is defined.
module pp_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       perf_if_stall_cnt,
  output logic [31:0]       perf_dm_stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              if_elig;
  logic              dm_elig;
  logic              grant_if;

  // A requester whose valid is high this cycle still shows its old req, so it cannot compete.
  assign if_elig  = if_req & ~if_valid;
  assign dm_elig  = dm_req & ~dm_valid;
  assign grant_if = if_elig & (~dm_elig | (starve_cnt == STARVE_LIM));

  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_req & ~dm_valid;
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_en     <= 1'b0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= BUSY_IF;
            mem_en     <= 1'b1;
            lat_addr   <= if_addr;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            starve_cnt <= '0;
          end else if (dm_elig) begin
            state     <= BUSY_DM;
            mem_en    <= 1'b1;
            lat_addr  <= dm_addr;
            lat_we    <= dm_we;
            lat_wdata <= dm_wdata;
            if (if_elig && (starve_cnt != STARVE_LIM))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata <= lat_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            if_valid <= 1'b1;
            mem_en   <= 1'b0;
            state    <= IDLE;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            if (!lat_we)
              dm_rdata <= mem_rdata;
            dm_valid <= 1'b1;
            mem_en   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Free-running stall-cycle counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_if_stall_cnt <= 32'd0;
      perf_dm_stall_cnt <= 32'd0;
    end else begin
      if (if_stall)
        perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
      if (dm_stall)
        perf_dm_stall_cnt <= perf_dm_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_if_stall_cnt = 32'd0;
  assign perf_dm_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pp_mem_arbiter.sv
// Self-checking bench for pp_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_pp_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] perf_if_stall_cnt;
  logic [31:0] perf_dm_stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  pp_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
    .clk               (clk),
    .reset             (reset),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_rdata          (if_rdata),
    .if_valid          (if_valid),
    .if_stall          (if_stall),
    .dm_req            (dm_req),
    .dm_we             (dm_we),
    .dm_addr           (dm_addr),
    .dm_wdata          (dm_wdata),
    .dm_rdata          (dm_rdata),
    .dm_valid          (dm_valid),
    .dm_stall          (dm_stall),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ready         (mem_ready),
    .perf_if_stall_cnt (perf_if_stall_cnt),
    .perf_dm_stall_cnt (perf_dm_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Transaction-level reference: one outstanding access, its owner and captured request.
  logic        m_busy;
  logic        m_who_if;
  logic [63:0] m_addr;
  logic        m_we;
  logic [63:0] m_wdata;
  logic        m_if_valid;
  logic        m_dm_valid;
  logic [31:0] m_if_rdata;
  logic [63:0] m_dm_rdata;
  int          m_starve;
  logic [31:0] m_pif;
  logic [31:0] m_pdm;
  logic        m_ie;
  logic        m_de;

  assign m_ie = if_req & ~m_if_valid;
  assign m_de = dm_req & ~m_dm_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy     <= 1'b0;
      m_who_if   <= 1'b0;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_wdata    <= '0;
      m_if_valid <= 1'b0;
      m_dm_valid <= 1'b0;
      m_if_rdata <= '0;
      m_dm_rdata <= '0;
      m_starve   <= 0;
      m_pif      <= '0;
      m_pdm      <= '0;
    end else begin
      m_if_valid <= 1'b0;
      m_dm_valid <= 1'b0;
      if (m_ie) m_pif <= m_pif + 32'd1;
      if (m_de) m_pdm <= m_pdm + 32'd1;
      if (m_busy) begin
        if (mem_ready) begin
          m_busy <= 1'b0;
          if (m_who_if) begin
            m_if_rdata <= m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            m_if_valid <= 1'b1;
          end else begin
            if (!m_we) m_dm_rdata <= mem_rdata;
            m_dm_valid <= 1'b1;
          end
        end
      end else if (m_ie && (!m_de || m_starve == STARVE_MAX)) begin
        m_busy   <= 1'b1;
        m_who_if <= 1'b1;
        m_addr   <= if_addr;
        m_we     <= 1'b0;
        m_wdata  <= '0;
        m_starve <= 0;
      end else if (m_de) begin
        m_busy   <= 1'b1;
        m_who_if <= 1'b0;
        m_addr   <= dm_addr;
        m_we     <= dm_we;
        m_wdata  <= dm_wdata;
        if (m_ie && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("mem_en", 64'(mem_en), 64'(m_busy));
      if (m_busy) begin
        checkOutput("mem_we", 64'(mem_we), 64'(m_we));
        checkOutput("mem_addr", mem_addr, m_addr);
        checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
      checkOutput("if_valid", 64'(if_valid), 64'(m_if_valid));
      checkOutput("dm_valid", 64'(dm_valid), 64'(m_dm_valid));
      checkOutput("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
      checkOutput("dm_rdata", dm_rdata, m_dm_rdata);
      checkOutput("if_stall", 64'(if_stall), 64'(m_ie));
      checkOutput("dm_stall", 64'(dm_stall), 64'(m_de));
`ifdef ARB_PERF_CNT_EN
      checkOutput("perf_if", 64'(perf_if_stall_cnt), 64'(m_pif));
      checkOutput("perf_dm", 64'(perf_dm_stall_cnt), 64'(m_pdm));
`else
      checkOutput("perf_if", 64'(perf_if_stall_cnt), 64'd0);
      checkOutput("perf_dm", 64'(perf_dm_stall_cnt), 64'd0);
`endif
    end
  end

  task automatic applyStimulus();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int          seen;
    logic [9:0]  order;
    logic [31:0] exp_perf;

    reset = 1'b1; if_req = 1'b1; if_addr = 64'h4;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    applyStimulus();
    checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
    checkOutput("rst_dm_valid", 64'(dm_valid), 64'd0);
    checkOutput("rst_if_rdata", 64'(if_rdata), 64'd0);
    checkOutput("rst_dm_rdata", dm_rdata, 64'd0);
    checkOutput("rst_mem_addr", mem_addr, 64'd0);
    reset = 1'b0;

    applyStimulus();
    checkOutput("rel_mem_en", 64'(mem_en), 64'd1);
    checkOutput("rel_mem_addr", mem_addr, 64'h4);
    checkOutput("rel_mem_we", 64'(mem_we), 64'd0);
    mem_ready = 1'b1; mem_rdata = 64'hAAAA_BBBB_1111_2222;

    applyStimulus();
    checkOutput("fetch_valid", 64'(if_valid), 64'd1);
    checkOutput("fetch_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
    checkOutput("fetch_mem_en_drop", 64'(mem_en), 64'd0);
    if_req = 1'b0; mem_ready = 1'b0;

    applyStimulus();
    checkOutput("fetch_valid_pulse", 64'(if_valid), 64'd0);
    checkOutput("fetch_rdata_hold", 64'(if_rdata), 64'hAAAA_BBBB);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h100; dm_wdata = 64'hDEAD;

    applyStimulus();
    checkOutput("store_mem_en", 64'(mem_en), 64'd1);
    checkOutput("store_mem_we", 64'(mem_we), 64'd1);
    checkOutput("store_mem_addr", mem_addr, 64'h100);
    checkOutput("store_mem_wdata", mem_wdata, 64'hDEAD);
    checkOutput("store_dm_stall", 64'(dm_stall), 64'd1);
    mem_ready = 1'b1; mem_rdata = 64'h5555;

    applyStimulus();
    checkOutput("store_valid", 64'(dm_valid), 64'd1);
    checkOutput("store_rdata_kept", dm_rdata, 64'd0);
    dm_we = 1'b0; mem_ready = 1'b0;

    applyStimulus();
    checkOutput("stale_req_no_grant", 64'(mem_en), 64'd0);

    applyStimulus();
    checkOutput("load_mem_en", 64'(mem_en), 64'd1);
    checkOutput("load_mem_we", 64'(mem_we), 64'd0);
    checkOutput("load_mem_addr", mem_addr, 64'h100);
    mem_ready = 1'b1; mem_rdata = 64'hDEAD;

    applyStimulus();
    checkOutput("load_valid", 64'(dm_valid), 64'd1);
    checkOutput("load_rdata", dm_rdata, 64'hDEAD);
    dm_req = 1'b0; mem_ready = 1'b0;

    applyStimulus();
    dm_req = 1'b1; dm_addr = 64'h200;
    applyStimulus();
    checkOutput("busy_dm_mem_en", 64'(mem_en), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_en", 64'(mem_en), 64'd0);
    dm_req = 1'b0;
    applyStimulus();
    reset = 1'b0; mem_ready = 1'b1;
    applyStimulus();
    checkOutput("late_ready_ignored", 64'(dm_valid), 64'd0);
    mem_ready = 1'b0;

    // Three stalled cycles: request, busy wait, completion edge.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h300;
    applyStimulus();
    applyStimulus();
    mem_ready = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    applyStimulus();
`ifdef ARB_PERF_CNT_EN
    exp_perf = 32'd3;
`else
    exp_perf = 32'd0;
`endif
    checkOutput("perf_dm_3", 64'(perf_dm_stall_cnt), 64'(exp_perf));
    checkOutput("perf_if_0", 64'(perf_if_stall_cnt), 64'd0);
    dm_req = 1'b0; mem_ready = 1'b0;
    applyStimulus();

    // Both requesters withdraw during any valid cycle so they compete again in the next idle cycle.
    seen = 0; order = '0; mem_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && seen < 10; cyc++) begin
      if (if_valid || dm_valid) begin
        order = {order[8:0], if_valid};
        seen++;
        if_req = 1'b0; dm_req = 1'b0;
      end else begin
        if_req = 1'b1; if_addr = 64'h1000 + 64'(cyc * 4);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000 + 64'(cyc * 8);
      end
      mem_rdata = {$urandom(), $urandom()};
      applyStimulus();
    end
    checkOutput("contention_seen", 64'(seen), 64'd10);
    checkOutput("contention_order", 64'(order), 64'(10'b0000100001));
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    repeat (2) applyStimulus();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) reset = 1'b1;
      else reset = 1'b0;
      if (if_valid || !if_req) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = {$urandom(), $urandom()} & ~64'h3;
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (dm_valid || !dm_req) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = {$urandom(), $urandom()};
        dm_wdata = {$urandom(), $urandom()};
      end else if ($urandom_range(0, 15) == 0) begin
        dm_req = 1'b0;
      end
      mem_ready = mem_en ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom(), $urandom()};
      applyStimulus();
    end
    reset = 1'b0;
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
